pzbcm_fifo_packer: RTL and testbench



---
 rtl/pzbcm_fifo_packer.sv | 132 +++++++++++++
 tb/tb_pzbcm_fifo_packer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pzbcm_fifo_packer.sv
// Packs RATIO show-ahead FIFO words into one wide valid/ready beat; i_last closes a partial beat.
// Optional idle flush of partial beats: define PZBCM_FIFO_PACKER_TIMEOUT_EN.
module pzbcm_fifo_packer #(
    parameter int WIDTH   = 8,
    parameter int RATIO   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_empty,
    output logic                       o_pop,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_last,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [WIDTH*RATIO-1:0]     o_data,
    output logic                       o_last,
    output logic [$clog2(RATIO+1)-1:0] o_count
);
    localparam int IW = $clog2(RATIO);
    localparam int CW = $clog2(RATIO + 1);
    localparam int BW = WIDTH * RATIO;

    if (RATIO < 2) begin : g_ratio_check
        $error("pzbcm_fifo_packer: RATIO must be >= 2");
    end
    if (TIMEOUT < 1) begin : g_timeout_check
        $error("pzbcm_fifo_packer: TIMEOUT must be >= 1");
    end

    typedef enum logic {FILL, HOLD} state_t;

    state_t          state;
    logic [BW-1:0]   acc;
    logic [BW-1:0]   merged;
    logic [IW-1:0]   idx;
    logic            hold_last;
    logic [CW-1:0]   hold_count;
    logic            free;
    logic            complete;
    logic            flush;
    logic [BW-1:0]   done_data;
    logic            done_last;
    logic [CW-1:0]   done_count;

    assign free  = !o_valid || i_ready;
    assign o_pop = (state == FILL) && !i_empty;

    always_comb begin
        merged = acc;
        merged[idx*WIDTH +: WIDTH] = i_data;
    end

`ifdef PZBCM_FIFO_PACKER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] idle_cnt;
    logic          idle;

    assign idle  = (state == FILL) && i_empty && (idx != '0);
    assign flush = idle && (idle_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idle_cnt <= '0;
        end else if (!idle || flush) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end
`else
    assign flush = 1'b0;
`endif

    // A flush completes on the accumulator alone; no word is popped that cycle.
    assign complete   = (o_pop && ((idx == IW'(RATIO - 1)) || i_last)) || flush;
    assign done_data  = flush ? acc : merged;
    assign done_last  = flush ? 1'b0 : i_last;
    assign done_count = flush ? CW'(idx) : CW'(idx) + CW'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= FILL;
            acc        <= '0;
            idx        <= '0;
            hold_last  <= 1'b0;
            hold_count <= '0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_last     <= 1'b0;
            o_count    <= '0;
        end else begin
            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
            case (state)
                FILL: begin
                    if (complete) begin
                        if (free) begin
                            o_valid <= 1'b1;
                            o_data  <= done_data;
                            o_last  <= done_last;
                            o_count <= done_count;
                            acc     <= '0;
                            idx     <= '0;
                        end else begin
                            acc        <= done_data;
                            hold_last  <= done_last;
                            hold_count <= done_count;
                            state      <= HOLD;
                        end
                    end else if (o_pop) begin
                        acc <= merged;
                        idx <= idx + IW'(1);
                    end
                end
                HOLD: begin
                    if (free) begin
                        o_valid <= 1'b1;
                        o_data  <= acc;
                        o_last  <= hold_last;
                        o_count <= hold_count;
                        acc     <= '0;
                        idx     <= '0;
                        state   <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_pzbcm_fifo_packer.sv
// Directed bench for pzbcm_fifo_packer (WIDTH=8, RATIO=4) with a queue standing in for the FIFO.
module tb_pzbcm_fifo_packer;
    localparam int WIDTH   = 8;
    localparam int RATIO   = 4;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        empty;
    logic        pop;
    logic [7:0]  data;
    logic        last;
    logic        valid;
    logic        ready;
    logic [31:0] beat;
    logic        beat_last;
    logic [2:0]  count;

    logic [8:0]  fq[$];
    logic        popped;
    int          pops;
    int          n_pass = 0;
    int          n_total = 0;

    pzbcm_fifo_packer #(.WIDTH(WIDTH), .RATIO(RATIO), .TIMEOUT(TIMEOUT)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_empty (empty),
        .o_pop   (pop),
        .i_data  (data),
        .i_last  (last),
        .o_valid (valid),
        .i_ready (ready),
        .o_data  (beat),
        .o_last  (beat_last),
        .o_count (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        fq.push_back({l, d});
    endtask

    // Called at a negedge: present the FIFO head, run one posedge, return at the next negedge.
    task automatic tick();
        empty = (fq.size() == 0);
        if (fq.size() > 0) {last, data} = fq[0];
        else begin
            data = '0;
            last = 1'b0;
        end
        #1;
        popped = pop;
        @(posedge clk);
        if (popped) begin
            void'(fq.pop_front());
            pops++;
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        empty = 1'b1;
        data  = '0;
        last  = 1'b0;
        ready = 1'b1;
        pops  = 0;
        @(negedge clk);
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_data", beat, 0);
        chk("rst_last", beat_last, 0);
        chk("rst_count", count, 0);
        chk("rst_pop", pop, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // full beat
        push(8'h11, 0); push(8'h22, 0); push(8'h33, 0); push(8'h44, 0);
        tick(); tick(); tick();
        chk("full_not_yet", valid, 0);
        tick();
        chk("full_valid", valid, 1);
        chk("full_data", beat, 32'h44332211);
        chk("full_count", count, 4);
        chk("full_last", beat_last, 0);
        tick();
        chk("full_drop", valid, 0);

        // early last, then a 1-word packet starting at lane 0
        push(8'hA1, 0); push(8'hA2, 1);
        tick(); tick();
        chk("part_valid", valid, 1);
        chk("part_data", beat, 32'h0000A2A1);
        chk("part_count", count, 2);
        chk("part_last", beat_last, 1);
        push(8'hB1, 1);
        tick();
        chk("one_valid", valid, 1);
        chk("one_data", beat, 32'h000000B1);
        chk("one_count", count, 1);
        chk("one_last", beat_last, 1);
        tick();
        chk("one_drop", valid, 0);

        // 12 words streamed at full rate
        pops = 0;
        for (int i = 1; i <= 12; i++) push(8'(i), 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i % 4 == 3) begin
                chk("stream_valid", valid, 1);
                chk("stream_data", beat, {8'(i + 1), 8'(i), 8'(i - 1), 8'(i - 2)});
            end else begin
                chk("stream_gap", valid, 0);
            end
        end
        chk("stream_pops", pops, 12);
        chk("stream_last_beat", beat, 32'h0C0B0A09);
        tick();

        // backpressure into HOLD
        pops  = 0;
        ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'h21 + 8'(i), 0);
        for (int i = 0; i < 8; i++) tick();
        chk("bp_pops", pops, 8);
        chk("bp_valid", valid, 1);
        chk("bp_stable", beat, 32'h24232221);
        push(8'h29, 0);
        tick(); tick();
        chk("hold_no_pop", pops, 8);
        chk("hold_stable", beat, 32'h24232221);
        ready = 1'b1;
        tick();
        chk("hold_release_valid", valid, 1);
        chk("hold_release_data", beat, 32'h28272625);
        chk("hold_release_count", count, 4);
        tick();
        chk("refill_pop", pops, 9);
        chk("refill_drop", valid, 0);
        push(8'h2A, 1);
        tick();
        chk("refill_data", beat, 32'h00002A29);
        chk("refill_count", count, 2);
        tick();

        // reset mid-packet
        push(8'h51, 0); push(8'h52, 0);
        tick(); tick();
        rst_n = 1'b0;
        fq.delete();
        #1;
        chk("mrst_valid", valid, 0);
        chk("mrst_data", beat, 0);
        chk("mrst_last", beat_last, 0);
        chk("mrst_count", count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        push(8'h61, 0); push(8'h62, 0); push(8'h63, 0); push(8'h64, 0);
        tick(); tick(); tick(); tick();
        chk("mrst_repack", beat, 32'h64636261);
        chk("mrst_repack_count", count, 4);

        // idle partial beat
        push(8'h71, 0);
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("idle_15", valid, 0);
        tick();
`ifdef PZBCM_FIFO_PACKER_TIMEOUT_EN
        chk("to_valid", valid, 1);
        chk("to_data", beat, 32'h00000071);
        chk("to_count", count, 1);
        chk("to_last", beat_last, 0);
        tick();
`else
        for (int i = 0; i < 24; i++) tick();
        chk("no_to_valid", valid, 0);
        push(8'h72, 1);
        tick();
        chk("no_to_data", beat, 32'h00007271);
        chk("no_to_count", count, 2);
        chk("no_to_last", beat_last, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
